// File: rtl/vscale_pipe_ctrl_pkg.sv
// vscale_pipe_ctrl_pkg: shared FSM encodings and forwarding constants for pipeline control
package vscale_pipe_ctrl_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_REPLAY = 1'b1} state_e;
  localparam int FWD_SEL_RF = 0;
endpackage

// File: rtl/vscale_fwd_match.sv
// vscale_fwd_match: youngest-stage priority matcher for one source operand
module vscale_fwd_match
  import vscale_pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LOAD_DATA_STAGE = DEPTH,
  parameter int AW = 5,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [DEPTH-1:0]         wr_i,
  input  logic [DEPTH-1:0]         is_load_i,
  input  logic [DEPTH-1:0][AW-1:0] rd_i,
  input  logic [AW-1:0]            addr_i,
  input  logic                     used_i,
  output logic [SEL_W-1:0]         sel_o,
  output logic                     hazard_o
);
  // Scan oldest to youngest so the lowest matching stage is the last to write.
  always_comb begin
    sel_o = SEL_W'(FWD_SEL_RF);
    hazard_o = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid_i[k-1] && wr_i[k-1] && rd_i[k-1] == addr_i && used_i && addr_i != '0) begin
        hazard_o = is_load_i[k-1] && (k < LOAD_DATA_STAGE);
        sel_o = hazard_o ? SEL_W'(FWD_SEL_RF) : SEL_W'(k);
      end
    end
  end
endmodule

// File: rtl/vscale_pipe_ctrl.sv
// vscale_pipe_ctrl: in-flight write tracking, bypass select, stall/kill and IF replay control
module vscale_pipe_ctrl
  import vscale_pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LOAD_DATA_STAGE = DEPTH,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      dx_valid,
  input  logic                      dx_wr_reg,
  input  logic                      dx_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] dx_rd,
  input  logic [REG_ADDR_WIDTH-1:0] dx_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] dx_rs2,
  input  logic                      dx_uses_rs1,
  input  logic                      dx_uses_rs2,
  input  logic                      redirect,
  input  logic                      imem_wait,
  input  logic                      dmem_wait,
  input  logic                      exception,
  output logic                      stall_if,
  output logic                      kill_if,
  output logic                      stall_dx,
  output logic                      kill_dx,
  output logic [DEPTH-1:0]          stage_valid,
  output logic                      wr_reg_wb,
  output logic [REG_ADDR_WIDTH-1:0] rd_wb,
  output logic [SEL_W-1:0]          fwd_rs1_sel,
  output logic [SEL_W-1:0]          fwd_rs2_sel,
  output logic                      load_use,
  output logic [31:0]               instret
);
  logic [DEPTH-1:0] valid_q, wr_q, ld_q;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] rd_q;
  state_e state_q;
  logic [31:0] instret_q;
  logic hz1, hz2, retire;

  vscale_fwd_match #(.DEPTH(DEPTH), .LOAD_DATA_STAGE(LOAD_DATA_STAGE), .AW(REG_ADDR_WIDTH)) u_rs1 (
    .valid_i(valid_q), .wr_i(wr_q), .is_load_i(ld_q), .rd_i(rd_q),
    .addr_i(dx_rs1), .used_i(dx_uses_rs1), .sel_o(fwd_rs1_sel), .hazard_o(hz1)
  );

  vscale_fwd_match #(.DEPTH(DEPTH), .LOAD_DATA_STAGE(LOAD_DATA_STAGE), .AW(REG_ADDR_WIDTH)) u_rs2 (
    .valid_i(valid_q), .wr_i(wr_q), .is_load_i(ld_q), .rd_i(rd_q),
    .addr_i(dx_rs2), .used_i(dx_uses_rs2), .sel_o(fwd_rs2_sel), .hazard_o(hz2)
  );

  assign load_use = dx_valid && (hz1 || hz2);
  assign stall_dx = dmem_wait || load_use;
  assign kill_dx = stall_dx || exception;
  assign stall_if = ((imem_wait && !redirect) || stall_dx) && !exception;
  assign kill_if = stall_if || redirect || exception || state_q == ST_REPLAY;
  assign retire = valid_q[DEPTH-1] && !dmem_wait && !exception;
  assign wr_reg_wb = retire && wr_q[DEPTH-1];
  assign rd_wb = rd_q[DEPTH-1];
  assign stage_valid = valid_q;
  assign instret = instret_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      wr_q <= '0;
      ld_q <= '0;
      rd_q <= '0;
      state_q <= ST_REPLAY;
      instret_q <= '0;
    end else begin
      if (!dmem_wait) begin
        for (int k = DEPTH - 1; k >= 1; k--) begin
          valid_q[k] <= valid_q[k-1];
          wr_q[k] <= wr_q[k-1];
          ld_q[k] <= ld_q[k-1];
          rd_q[k] <= rd_q[k-1];
        end
        valid_q[0] <= dx_valid && !kill_dx;
        wr_q[0] <= dx_wr_reg;
        ld_q[0] <= dx_is_load;
        rd_q[0] <= dx_rd;
      end
      if (exception) valid_q <= '0;
      if (retire) instret_q <= instret_q + 32'd1;
      // A stalled DX re-presents its redirect next cycle, so only an unstalled one arms replay.
      if (state_q == ST_RUN)
        state_q <= ((redirect || exception) && imem_wait && !stall_dx) ? ST_REPLAY : ST_RUN;
      else
        state_q <= (!imem_wait && !exception) ? ST_RUN : ST_REPLAY;
    end
  end
endmodule

// File: tb/tb_vscale_pipe_ctrl.sv
// tb_vscale_pipe_ctrl: directed and randomized checks against an in-bench pipeline model
module tb_vscale_pipe_ctrl;
  localparam int D = 3;
  localparam int LDS = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic dx_valid = 0, dx_wr_reg = 0, dx_is_load = 0;
  logic [4:0] dx_rd = 0, dx_rs1 = 0, dx_rs2 = 0;
  logic dx_uses_rs1 = 0, dx_uses_rs2 = 0;
  logic redirect = 0, imem_wait = 0, dmem_wait = 0, exception = 0;
  logic stall_if, kill_if, stall_dx, kill_dx, wr_reg_wb, load_use;
  logic [D-1:0] stage_valid;
  logic [4:0] rd_wb;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] instret;

  vscale_pipe_ctrl #(.DEPTH(D), .LOAD_DATA_STAGE(LDS), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n), .dx_valid(dx_valid), .dx_wr_reg(dx_wr_reg),
    .dx_is_load(dx_is_load), .dx_rd(dx_rd), .dx_rs1(dx_rs1), .dx_rs2(dx_rs2),
    .dx_uses_rs1(dx_uses_rs1), .dx_uses_rs2(dx_uses_rs2), .redirect(redirect),
    .imem_wait(imem_wait), .dmem_wait(dmem_wait), .exception(exception),
    .stall_if(stall_if), .kill_if(kill_if), .stall_dx(stall_dx), .kill_dx(kill_dx),
    .stage_valid(stage_valid), .wr_reg_wb(wr_reg_wb), .rd_wb(rd_wb),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .load_use(load_use),
    .instret(instret)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  // Model: one record per post-DX slot, index 1 = youngest.
  bit mv[1:D], mwr[1:D], mld[1:D];
  logic [4:0] mrd[1:D];
  bit mrep;
  logic [31:0] mcnt;
  int e_sel1, e_sel2;
  bit e_hz1, e_hz2, e_lu, e_sdx, e_kdx, e_sif, e_kif, e_wb;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    else passed++;
  endtask

  task automatic model_reset();
    for (int k = 1; k <= D; k++) begin mv[k] = 0; mwr[k] = 0; mld[k] = 0; mrd[k] = 0; end
    mrep = 1;
    mcnt = 0;
  endtask

  task automatic msearch(input logic [4:0] a, input logic u, output int sel, output bit hz);
    sel = 0;
    hz = 0;
    for (int k = 1; k <= D; k++) begin
      if (mv[k] && mwr[k] && mrd[k] == a && u && a != 0) begin
        hz = mld[k] && k < LDS;
        sel = hz ? 0 : k;
        break;
      end
    end
  endtask

  task automatic expect_now();
    msearch(dx_rs1, dx_uses_rs1, e_sel1, e_hz1);
    msearch(dx_rs2, dx_uses_rs2, e_sel2, e_hz2);
    e_lu = dx_valid && (e_hz1 || e_hz2);
    e_sdx = dmem_wait || e_lu;
    e_kdx = e_sdx || exception;
    e_sif = ((imem_wait && !redirect) || e_sdx) && !exception;
    e_kif = e_sif || redirect || exception || mrep;
    e_wb = mv[D] && mwr[D] && !dmem_wait && !exception;
  endtask

  task automatic step_chk();
    @(negedge clk);
    expect_now();
    chk("stall_if", stall_if, e_sif);
    chk("kill_if", kill_if, e_kif);
    chk("stall_dx", stall_dx, e_sdx);
    chk("kill_dx", kill_dx, e_kdx);
    chk("load_use", load_use, e_lu);
    chk("fwd_rs1_sel", fwd_rs1_sel, e_sel1);
    chk("fwd_rs2_sel", fwd_rs2_sel, e_sel2);
    chk("stage_valid", stage_valid, {mv[3], mv[2], mv[1]});
    chk("wr_reg_wb", wr_reg_wb, e_wb);
    if (e_wb) chk("rd_wb", rd_wb, mrd[D]);
    chk("instret", instret, mcnt);
  endtask

  task automatic adv();
    expect_now();
    @(posedge clk);
    if (mv[D] && !dmem_wait && !exception) mcnt = mcnt + 1;
    if (!mrep) mrep = (redirect || exception) && imem_wait && !e_sdx;
    else mrep = imem_wait || exception;
    if (!dmem_wait) begin
      for (int k = D; k >= 2; k--) begin
        mv[k] = mv[k-1]; mwr[k] = mwr[k-1]; mld[k] = mld[k-1]; mrd[k] = mrd[k-1];
      end
      mv[1] = dx_valid && !e_kdx;
      mwr[1] = dx_wr_reg;
      mld[1] = dx_is_load;
      mrd[1] = dx_rd;
    end
    if (exception) for (int k = 1; k <= D; k++) mv[k] = 0;
    #1;
  endtask

  task automatic cyc();
    step_chk();
    adv();
  endtask

  task automatic dx(input logic v, input logic w, input logic l, input logic [4:0] rd,
                    input logic [4:0] rs1, input logic u1);
    dx_valid = v; dx_wr_reg = w; dx_is_load = l; dx_rd = rd; dx_rs1 = rs1; dx_uses_rs1 = u1;
    dx_rs2 = 0; dx_uses_rs2 = 0;
  endtask

  task automatic randomize_inputs();
    dx_valid = $urandom_range(0, 3) != 0;
    dx_wr_reg = $urandom_range(0, 3) != 0;
    dx_is_load = $urandom_range(0, 2) == 0;
    dx_rd = 5'($urandom_range(0, 7));
    dx_rs1 = 5'($urandom_range(0, 7));
    dx_rs2 = 5'($urandom_range(0, 7));
    dx_uses_rs1 = $urandom_range(0, 3) != 0;
    dx_uses_rs2 = $urandom_range(0, 1) != 0;
    redirect = $urandom_range(0, 5) == 0;
    imem_wait = $urandom_range(0, 3) == 0;
    dmem_wait = $urandom_range(0, 5) == 0;
    exception = $urandom_range(0, 30) == 0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, stage_valid, 0);
    chk({tag, "_kill_if"}, kill_if, 1);
    chk({tag, "_wr_reg_wb"}, wr_reg_wb, 0);
    chk({tag, "_sel1"}, fwd_rs1_sel, 0);
    chk({tag, "_sel2"}, fwd_rs2_sel, 0);
    chk({tag, "_load_use"}, load_use, 0);
    chk({tag, "_instret"}, instret, 0);
  endtask

  logic [31:0] saved;

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    #1 check_reset_values("reset");
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Back-to-back writes to x5, then a reader: youngest stage wins.
    dx(1, 1, 0, 5, 0, 0);
    cyc();
    cyc();
    dx(1, 0, 0, 0, 5, 1);
    step_chk();
    chk("x5_sel", fwd_rs1_sel, 1);
    chk("x5_load_use", load_use, 0);
    adv();

    // Load to x7 then immediate use: one stall cycle, then bypass from stage 2.
    dx(1, 1, 1, 7, 0, 0);
    cyc();
    dx(1, 0, 0, 0, 7, 1);
    step_chk();
    chk("ld_use_1", load_use, 1);
    adv();
    step_chk();
    chk("ld_use_2", load_use, 0);
    chk("ld_sel", fwd_rs1_sel, 2);
    adv();
    dx(0, 0, 0, 0, 0, 0);
    repeat (3) cyc();
    step_chk();
    chk("instret_drain", instret, 5);
    adv();

    // Writes to x0 never forward.
    dx(1, 1, 0, 0, 0, 0);
    cyc();
    dx(1, 0, 0, 0, 0, 1);
    step_chk();
    chk("x0_sel", fwd_rs1_sel, 0);
    chk("x0_load_use", load_use, 0);
    chk("x0_stall_dx", stall_dx, 0);
    adv();
    dx(0, 0, 0, 0, 0, 0);

    // Redirect under imem_wait: IF killed until fetch returns, then RUN.
    redirect = 1; imem_wait = 1;
    step_chk();
    chk("redir_kill_if", kill_if, 1);
    adv();
    redirect = 0;
    for (int i = 0; i < 3; i++) begin
      step_chk();
      chk("replay_kill_if", kill_if, 1);
      adv();
    end
    imem_wait = 0;
    step_chk();
    chk("replay_exit_kill_if", kill_if, 1);
    adv();
    step_chk();
    chk("run_kill_if", kill_if, 0);
    adv();

    // Full pipe held by dmem_wait, then flushed by exception.
    for (int i = 1; i <= 3; i++) begin
      dx(1, 1, 0, 5'(i), 0, 0);
      cyc();
    end
    saved = mcnt;
    dmem_wait = 1;
    for (int i = 0; i < 4; i++) begin
      step_chk();
      chk("dwait_wr_reg_wb", wr_reg_wb, 0);
      chk("dwait_valid", stage_valid, 3'b111);
      adv();
    end
    exception = 1;
    step_chk();
    chk("exc_wr_reg_wb", wr_reg_wb, 0);
    adv();
    exception = 0; dmem_wait = 0;
    dx(0, 0, 0, 0, 0, 0);
    step_chk();
    chk("exc_valid", stage_valid, 0);
    chk("exc_instret", instret, saved);
    adv();

    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      cyc();
    end

    // Asynchronous reset mid-stream, away from any clock edge.
    #2 reset_n = 1'b0;
    dx_valid = 1; dx_uses_rs1 = 1; dx_uses_rs2 = 1;
    #1 check_reset_values("async_reset");
    model_reset();
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      randomize_inputs();
      cyc();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
